// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder and multiplier datapaths:
// field widths, the exponent bias and the packed/unpacked operand views.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SHIFT_W = 5;
  localparam int BIAS    = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Denormals are presented with eff_exp = 1 and hidden = 0, so the
  // exponent and {hidden, frac} compare directly against normals.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  eff_exp;
    logic              hidden;
    logic [FRAC_W-1:0] frac;
  } fp_unp_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one single-precision operand into sign,
// effective exponent, hidden bit and fraction.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [EXP_W+FRAC_W:0] op_i,
  output fp_unp_t               unp_o
);

  fp32_t op;
  assign op = op_i;

  // Zero exponent means denormal or zero: hidden bit clear, exponent reads as 1.
  always_comb begin
    unp_o.sign = op.sign;
    unp_o.frac = op.frac;
    if (op.exp == '0) begin
      unp_o.eff_exp = EXP_W'(1);
      unp_o.hidden  = 1'b0;
    end else begin
      unp_o.eff_exp = op.exp;
      unp_o.hidden  = 1'b1;
    end
  end

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage pre-alignment for the FP adder: unpack and compare exponents,
// then order operands into big/small and produce the shifter controls.
// Widths must match fp_pkg, since the unpacked record type comes from there.
module fp_align_prep
  import fp_pkg::*;
#(
  parameter int EXP_W   = fp_pkg::EXP_W,
  parameter int FRAC_W  = fp_pkg::FRAC_W,
  parameter int SHIFT_W = fp_pkg::SHIFT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  big_sign,
  output logic [EXP_W-1:0]      big_exp,
  output logic [FRAC_W:0]       big_mant,
  output logic [FRAC_W-1:0]     small_frac,
  output logic                  small_hidden,
  output logic [SHIFT_W-1:0]    shift_amt,
  output logic                  far,
  output logic                  eff_sub,
  output logic                  special
);

  // Saturate the exponent difference to the largest shift the shifter takes.
  function automatic logic [SHIFT_W-1:0] sat_shift(input logic [EXP_W-1:0] d);
    if (d > EXP_W'((1 << SHIFT_W) - 1)) return '1;
    return d[SHIFT_W-1:0];
  endfunction

  localparam logic [EXP_W-1:0] FAR_LIM = EXP_W'(FRAC_W + 1);

  logic adv_p1, adv_p2;
  logic vld_p1_q, vld_p2_q;

  // ---- stage 1: unpack, compare, difference ----
  fp_unp_t ua, ub;
  fp32_t   fa, fb;
  logic    a_big_d, special_d, eff_sub_d;
  logic [EXP_W-1:0] diff_d;

  assign fa = in_a;
  assign fb = in_b;

  fp_unpack u_unp_a (.op_i(in_a), .unp_o(ua));
  fp_unpack u_unp_b (.op_i(in_b), .unp_o(ub));

  // Exponent decides first; equal exponents fall back to the full mantissa.
  always_comb begin
    a_big_d = (ua.eff_exp > ub.eff_exp) ||
              ((ua.eff_exp == ub.eff_exp) &&
               ({ua.hidden, ua.frac} >= {ub.hidden, ub.frac}));
    diff_d    = a_big_d ? (ua.eff_exp - ub.eff_exp) : (ub.eff_exp - ua.eff_exp);
    special_d = (&fa.exp) | (&fb.exp);
    eff_sub_d = in_sub ^ ua.sign ^ ub.sign;
  end

  assign adv_p2   = !vld_p2_q || out_ready;
  assign adv_p1   = !vld_p1_q || adv_p2;
  assign in_ready = adv_p1;

  fp_unp_t          ua_p1_q, ub_p1_q;
  logic             a_big_p1_q, sub_p1_q, eff_sub_p1_q, special_p1_q;
  logic [EXP_W-1:0] diff_p1_q;

  // Stage-1 register: capture a pair only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      ua_p1_q      <= '0;
      ub_p1_q      <= '0;
      a_big_p1_q   <= 1'b0;
      sub_p1_q     <= 1'b0;
      eff_sub_p1_q <= 1'b0;
      special_p1_q <= 1'b0;
      diff_p1_q    <= '0;
    end else if (adv_p1) begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        ua_p1_q      <= ua;
        ub_p1_q      <= ub;
        a_big_p1_q   <= a_big_d;
        sub_p1_q     <= in_sub;
        eff_sub_p1_q <= eff_sub_d;
        special_p1_q <= special_d;
        diff_p1_q    <= diff_d;
      end
    end
  end

  // ---- stage 2: swap mux and shift saturation ----
  fp_unp_t          big_d, small_d;
  logic             big_sign_d;

  // b's sign is flipped by a subtraction opcode when b ends up as the big operand.
  always_comb begin
    big_d      = a_big_p1_q ? ua_p1_q : ub_p1_q;
    small_d    = a_big_p1_q ? ub_p1_q : ua_p1_q;
    big_sign_d = a_big_p1_q ? ua_p1_q.sign : (ub_p1_q.sign ^ sub_p1_q);
  end

  logic                  big_sign_p2_q, small_hidden_p2_q, far_p2_q;
  logic                  eff_sub_p2_q, special_p2_q;
  logic [EXP_W-1:0]      big_exp_p2_q;
  logic [FRAC_W:0]       big_mant_p2_q;
  logic [FRAC_W-1:0]     small_frac_p2_q;
  logic [SHIFT_W-1:0]    shift_amt_p2_q;

  // Stage-2 register: holds the output while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q          <= 1'b0;
      big_sign_p2_q     <= 1'b0;
      big_exp_p2_q      <= '0;
      big_mant_p2_q     <= '0;
      small_frac_p2_q   <= '0;
      small_hidden_p2_q <= 1'b0;
      shift_amt_p2_q    <= '0;
      far_p2_q          <= 1'b0;
      eff_sub_p2_q      <= 1'b0;
      special_p2_q      <= 1'b0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        big_sign_p2_q     <= big_sign_d;
        big_exp_p2_q      <= big_d.eff_exp;
        big_mant_p2_q     <= {big_d.hidden, big_d.frac};
        small_frac_p2_q   <= small_d.frac;
        small_hidden_p2_q <= small_d.hidden;
        shift_amt_p2_q    <= sat_shift(diff_p1_q);
        far_p2_q          <= (diff_p1_q > FAR_LIM);
        eff_sub_p2_q      <= eff_sub_p1_q;
        special_p2_q      <= special_p1_q;
      end
    end
  end

  assign out_valid    = vld_p2_q;
  assign big_sign     = big_sign_p2_q;
  assign big_exp      = big_exp_p2_q;
  assign big_mant     = big_mant_p2_q;
  assign small_frac   = small_frac_p2_q;
  assign small_hidden = small_hidden_p2_q;
  assign shift_amt    = shift_amt_p2_q;
  assign far          = far_p2_q;
  assign eff_sub      = eff_sub_p2_q;
  assign special      = special_p2_q;

endmodule
